// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency imem and
// presents a registered IF/ID word (inst, pc, pc+4, valid) to decode.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic [31:0]       inst_pc4,
  output logic              inst_valid,
  output logic              misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_pc4_q, inst_pc4_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misaligned_q, misaligned_d;

  // Re-request the in-flight word while decode is stalled so it is still there on release.
  always_comb begin
    if (state_q == RUN && stall) begin
      imem_addr = req_pc_q[ADDR_W+1:2];
    end else begin
      imem_addr = fetch_pc_q[ADDR_W+1:2];
    end
  end

  // Next-state and IF/ID payload; redirect overrides stall in every state.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_pc4_d   = inst_pc4_q;
    inst_valid_d = inst_valid_q;
    misaligned_d = 1'b0;

    if (redirect) begin
      fetch_pc_d   = {redirect_target[31:2], 2'b00};
      state_d      = FILL;
      inst_valid_d = 1'b0;
      inst_d       = NOP;
      misaligned_d = |redirect_target[1:0];
    end else if (!stall) begin
      case (state_q)
        FILL: begin
          req_pc_d     = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + 32'd4;
          inst_valid_d = 1'b0;
          state_d      = RUN;
        end
        RUN: begin
          inst_d       = imem_rdata;
          inst_pc_d    = req_pc_q;
          inst_pc4_d   = req_pc_q + 32'd4;
          inst_valid_d = 1'b1;
          req_pc_d     = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + 32'd4;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // State register with synchronous reset taking priority over stall and redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      fetch_pc_q   <= PC_RESET;
      req_pc_q     <= PC_RESET;
      inst_q       <= NOP;
      inst_pc_q    <= 32'h0;
      inst_pc4_q   <= 32'h0;
      inst_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_pc4_q   <= inst_pc4_d;
      inst_valid_q <= inst_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_pc4   = inst_pc4_q;
  assign inst_valid = inst_valid_q;
  assign misaligned = misaligned_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the RV32I core. Sits directly upstream of decode and immediate generation.
- Owns the PC register and drives a synchronous-read instruction memory. Presents a registered IF/ID word (inst, pc, pc+4, valid) to decode, where the immediate generator slices inst.
- Supports a decode-side stall and an execute-side redirect (taken branch, jal, jalr) with flush.

Parameters:
- PC_RESET, 32'h0000_0000, PC of the first fetched instruction after reset.
- ADDR_W, 14, imem word-address width; imem_addr = pc[ADDR_W+1:2].

Ports:
- clk  in  1  core clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- stall  in  1  decode cannot accept; freeze the IF/ID outputs and fetch progress.
- redirect  in  1  taken branch/jump resolved; flush and refetch.
- redirect_target  in  32  new PC (pc+imm32 for branch/jal, rs1+imm32 for jalr).
- imem_addr  out  ADDR_W  word address to imem. Combinational from internal state.
- imem_rdata  in  32  imem data, valid the cycle after the address is presented (1-cycle latency).
- inst  out  32  registered instruction to decode.
- inst_pc  out  32  registered PC of inst.
- inst_pc4  out  32  registered inst_pc+4, used as the jal/jalr link value.
- inst_valid  out  1  inst/inst_pc are a real instruction.
- misaligned  out  1  one-cycle pulse: redirect_target[1:0] was non-zero.

Behaviour:
- Internal state: fetch_pc (next address to request), req_pc (PC of the word imem returns this cycle), FSM state in {FILL, RUN}.
- Reset (rst=1 at edge), all fields below take these values:
  - fetch_pc=PC_RESET, req_pc=PC_RESET, state=FILL.
  - inst=32'h0000_0013 (NOP), inst_pc=0, inst_pc4=0, inst_valid=0, misaligned=0.
  - rst has priority over redirect and stall.
- imem_addr = (state==RUN && stall) ? req_pc[ADDR_W+1:2] : fetch_pc[ADDR_W+1:2].
  - Re-requesting req_pc during a stall keeps the in-flight word alive; no skid buffer is needed.
- FILL (no valid imem response this cycle):
  - redirect: handled by the redirect rule below.
  - else if stall: hold all state.
  - else: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4, inst_valid<=0, state->RUN.
- RUN (imem_rdata is the word at req_pc):
  - redirect: handled by the redirect rule below.
  - else if stall: hold fetch_pc, req_pc and all outputs; state stays RUN.
  - else: inst<=imem_rdata, inst_pc<=req_pc, inst_pc4<=req_pc+4, inst_valid<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
- Redirect rule (any state, overrides stall):
  - fetch_pc<={redirect_target[31:2],2'b00}, state->FILL.
  - inst_valid<=0, inst<=NOP; the in-flight word is dropped.
  - misaligned<=|redirect_target[1:0]; otherwise misaligned<=0 every cycle.
- Latency:
  - After reset: first inst_valid=1 visible 2 cycles after rst deasserts.
  - After redirect: target instruction visible with inst_valid=1 on the 2nd edge after the redirect edge, giving 2 bubbles.
- Throughput: one instruction per cycle with no stall/redirect.
- Arithmetic: PC adds are 32-bit and wrap mod 2^32 (32'hFFFF_FFFC+4 -> 0). imem_addr truncates the upper PC bits.
- Stall asserted in the same cycle as inst_valid=0: legal, holds the bubble.

Test Plan:
- Reset, then no stall, imem[i]=i+32'h100 -> cycle 2 after rst: inst=32'h100, inst_pc=0; next cycles inst_pc=4,8,12 with inst_valid=1 continuously.
- Stall for 3 cycles while inst_pc=8 -> inst/inst_pc/inst_valid frozen at (imem[2],8,1) and imem_addr=3 during stall; after release inst_pc=12 then 16, with no skipped or duplicated words.
- Redirect to 32'h40 while inst_pc=8 -> inst_valid=0 for 2 cycles, then inst_pc=32'h40, inst=imem[16]; misaligned stays 0.
- Redirect and stall asserted together, target 32'h42 -> redirect wins, misaligned=1 for one cycle, next fetch at 32'h40.
- rst asserted mid-stream while stall=1 and redirect=1 -> next cycle inst_valid=0, inst=32'h13, fetch restarts at PC_RESET.
- Wrap-around: PC_RESET=32'hFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, with inst_pc4 of the 2nd word = 0.
